// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC sample scheduler.
package dac_pkg;

  localparam int          DAC_DW       = 10;
  localparam logic [9:0]  DAC_MIDSCALE = 10'd512;
  localparam logic [7:0]  UNDERRUN_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PARK = 2'd2
  } sched_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == UNDERRUN_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dac_sample_sched_arb.sv
// Combinational round-robin arbiter: first set request at or above ptr_i, modulo NREQ.
module dac_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  input  logic                    en_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] gnt_idx_o,
  output logic                    any_o
);

  localparam int IW = $clog2(NREQ);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      // ptr_i < NREQ, so a single subtraction folds the search index back into range
      sum = {1'b0, ptr_i} + (IW+1)'(i);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      idx = sum[IW-1:0];
      if (en_i && !any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/dac_sample_sched.sv
// DAC sample-rate scheduler: programmable tick divider, round-robin source grant,
// registered DAC code and saturating underrun count. Optional parking via DAC_SCHED_PARK_EN.
//
// state | meaning
// IDLE  | disabled; divider cleared, no grants, dout holds
// RUN   | divider running; one grant (or underrun) per tick
// PARK  | (DAC_SCHED_PARK_EN) starved; dout walks one LSB per tick toward midscale
module dac_sample_sched
  import dac_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int DW    = DAC_DW,
  parameter int DIV_W = 16
`ifdef DAC_SCHED_PARK_EN
  ,
  parameter int PARK_T = 64
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic [DIV_W-1:0]        div_i,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*DW-1:0]      req_data_i,
  output logic [NREQ-1:0]         req_ready_o,
  output logic [DW-1:0]           dout,
  output logic                    dout_upd_o,
  output logic [$clog2(NREQ)-1:0] grant_idx_o,
  output logic [7:0]              underrun_o
);

  localparam int IW = $clog2(NREQ);

  sched_state_t   state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [DW-1:0]  dout_q, dout_d;
  logic           upd_q, upd_d;
  logic [IW-1:0]  gidx_q, gidx_d;
  logic [7:0]     under_q, under_d;

`ifdef DAC_SCHED_PARK_EN
  localparam int PCW = $clog2(PARK_T + 1);
  localparam logic [DW-1:0] MID = DW'(DAC_MIDSCALE);
  logic [PCW-1:0] park_cnt_q, park_cnt_d;
`endif

  logic            tick;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            any;
  logic [DW-1:0]   win_data;

  assign tick = (state_q != IDLE) && (cnt_q == div_q);

  dac_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i     (req_valid_i),
    .ptr_i     (ptr_q),
    .en_i      (tick),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (any)
  );

  always_comb begin
    win_data = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (gnt[r]) win_data = req_data_i[r*DW +: DW];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    ptr_d   = ptr_q;
    dout_d  = dout_q;
    upd_d   = 1'b0;
    gidx_d  = gidx_q;
    under_d = under_q;
`ifdef DAC_SCHED_PARK_EN
    park_cnt_d = park_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
`ifdef DAC_SCHED_PARK_EN
        park_cnt_d = '0;
`endif
        if (en_i) begin
          state_d = RUN;
          div_d   = div_i;
        end
      end
      default: begin
        if (tick) begin
          cnt_d = '0;
          div_d = div_i;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (!en_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
    endcase

    // A tick seen with en_i falling still completes its grant or underrun
    if (tick && any) begin
      dout_d = win_data;
      upd_d  = 1'b1;
      gidx_d = gnt_idx;
      ptr_d  = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
`ifdef DAC_SCHED_PARK_EN
      park_cnt_d = '0;
      if (state_q == PARK && en_i) state_d = RUN;
`endif
    end else if (tick && state_q == RUN) begin
      under_d = sat_inc8(under_q);
`ifdef DAC_SCHED_PARK_EN
      if (park_cnt_q == PCW'(PARK_T - 1)) begin
        park_cnt_d = '0;
        if (en_i) state_d = PARK;
      end else begin
        park_cnt_d = park_cnt_q + 1'b1;
      end
`endif
    end
`ifdef DAC_SCHED_PARK_EN
    else if (tick && state_q == PARK) begin
      if (dout_q > MID) begin
        dout_d = dout_q - 1'b1;
        upd_d  = 1'b1;
      end else if (dout_q < MID) begin
        dout_d = dout_q + 1'b1;
        upd_d  = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      ptr_q   <= '0;
      dout_q  <= '0;
      upd_q   <= 1'b0;
      gidx_q  <= '0;
      under_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      ptr_q   <= ptr_d;
      dout_q  <= dout_d;
      upd_q   <= upd_d;
      gidx_q  <= gidx_d;
      under_q <= under_d;
    end
  end

`ifdef DAC_SCHED_PARK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) park_cnt_q <= '0;
    else        park_cnt_q <= park_cnt_d;
  end
`endif

  assign req_ready_o = gnt;
  assign dout        = dout_q;
  assign dout_upd_o  = upd_q;
  assign grant_idx_o = gidx_q;
  assign underrun_o  = under_q;

endmodule

// File: tb/tb_dac_sample_sched.sv
// Self-checking bench for dac_sample_sched (default build, park feature off).
module tb_dac_sample_sched;

  localparam int NREQ  = 3;
  localparam int DW    = 10;
  localparam int DIV_W = 16;
  localparam int IW    = $clog2(NREQ);

  logic                clk;
  logic                rst_n;
  logic                en_i;
  logic [DIV_W-1:0]    div_i;
  logic [NREQ-1:0]     req_valid_i;
  logic [NREQ*DW-1:0]  req_data_i;
  logic [NREQ-1:0]     req_ready_o;
  logic [DW-1:0]       dout;
  logic                dout_upd_o;
  logic [IW-1:0]       grant_idx_o;
  logic [7:0]          underrun_o;

  dac_sample_sched #(.NREQ(NREQ), .DW(DW), .DIV_W(DIV_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en_i),
    .div_i       (div_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .dout        (dout),
    .dout_upd_o  (dout_upd_o),
    .grant_idx_o (grant_idx_o),
    .underrun_o  (underrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic en, input int dv, input logic [NREQ-1:0] v,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    en_i        = en;
    div_i       = DIV_W'(dv);
    req_valid_i = v;
    req_data_i  = {d2, d1, d0};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_upd(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!dout_upd_o && n < 50);
  endtask

  // Reference model: period bookkeeping plus round-robin search by modulo arithmetic
  bit         m_run;
  int         m_phase, m_period, m_ptr, m_gidx, m_under;
  logic [9:0] m_dout;
  bit         m_upd;

  task automatic model_reset();
    m_run = 0; m_phase = 0; m_period = 1; m_ptr = 0;
    m_gidx = 0; m_under = 0; m_dout = '0; m_upd = 0;
  endtask

  task automatic model_cycle();
    bit tk;
    int win;
    logic [NREQ-1:0] exp_rdy;
    tk  = m_run && (m_phase == m_period - 1);
    win = -1;
    for (int i = 0; i < NREQ; i++) begin
      int r;
      r = (m_ptr + i) % NREQ;
      if (win < 0 && req_valid_i[r]) win = r;
    end
    exp_rdy = '0;
    if (tk && win >= 0) exp_rdy[win] = 1'b1;
    check("ready", 32'(req_ready_o), 32'(exp_rdy));

    m_upd = 0;
    if (tk) begin
      if (win >= 0) begin
        m_dout = req_data_i[win*DW +: DW];
        m_upd  = 1;
        m_gidx = win;
        m_ptr  = (win + 1) % NREQ;
      end else if (m_under < 255) begin
        m_under++;
      end
    end
    if (!m_run) begin
      m_phase = 0;
      if (en_i) begin m_run = 1; m_period = int'(div_i) + 1; end
    end else begin
      if (tk) begin m_phase = 0; m_period = int'(div_i) + 1; end
      else m_phase++;
      if (!en_i) begin m_run = 0; m_phase = 0; end
    end
  endtask

  task automatic model_check_regs();
    check("dout", 32'(dout), 32'(m_dout));
    check("dout_upd", 32'(dout_upd_o), 32'(m_upd));
    check("grant_idx", 32'(grant_idx_o), 32'(m_gidx));
    check("underrun", 32'(underrun_o), 32'(m_under));
  endtask

  typedef struct {
    int              dv;
    logic [NREQ-1:0] valid;
    logic [DW-1:0]   d0;
    logic [DW-1:0]   d1;
    int              n;
    logic [DW-1:0]   e_dout;
    int              e_gidx;
    int              e_under;
    bit              e_upd;
  } vec_t;

  vec_t vt[6];

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    int n;
    rst_n = 1'b0;
    drive(1'b0, 0, '0, '0, '0, '0);

    vt[0] = '{3, 3'b001, 10'h155, 10'h000,   9, 10'h155, 0,   0, 1'b1};
    vt[1] = '{0, 3'b011, 10'h000, 10'h3FF,   5, 10'h3FF, 1,   0, 1'b1};
    vt[2] = '{1, 3'b000, 10'h000, 10'h000,  11, 10'h000, 0,   5, 1'b0};
    vt[3] = '{2, 3'b010, 10'h000, 10'h2AA,   4, 10'h2AA, 1,   0, 1'b1};
    vt[4] = '{0, 3'b000, 10'h000, 10'h000, 301, 10'h000, 0, 255, 1'b0};
    vt[5] = '{4, 3'b011, 10'h0AB, 10'h321,  16, 10'h0AB, 0,   0, 1'b1};

    do_reset();
    check("rst_dout", 32'(dout), 0);
    check("rst_upd", 32'(dout_upd_o), 0);
    check("rst_gidx", 32'(grant_idx_o), 0);
    check("rst_under", 32'(underrun_o), 0);
    check("rst_ready", 32'(req_ready_o), 0);

    for (int k = 0; k < 6; k++) begin
      do_reset();
      drive(1'b1, vt[k].dv, vt[k].valid, vt[k].d0, vt[k].d1, '0);
      repeat (vt[k].n) @(posedge clk);
      #1;
      check($sformatf("vec%0d_dout", k), 32'(dout), 32'(vt[k].e_dout));
      check($sformatf("vec%0d_gidx", k), 32'(grant_idx_o), 32'(vt[k].e_gidx));
      check($sformatf("vec%0d_under", k), 32'(underrun_o), 32'(vt[k].e_under));
      check($sformatf("vec%0d_upd", k), 32'(dout_upd_o), 32'(vt[k].e_upd));
    end

    // Async reset mid-period, then first tick timing after release
    do_reset();
    drive(1'b1, 2, 3'b000, '0, 10'h2AA, '0);
    repeat (7) @(posedge clk);
    #1 drive(1'b1, 2, 3'b010, '0, 10'h2AA, '0);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_dout", 32'(dout), 32'h2AA);
    check("pre_rst_under", 32'(underrun_o), 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dout", 32'(dout), 0);
    check("async_rst_under", 32'(underrun_o), 0);
    check("async_rst_gidx", 32'(grant_idx_o), 0);
    check("async_rst_ready", 32'(req_ready_o), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_upd(n);
    check("post_rst_first_tick", n, 4);
    check("post_rst_dout", 32'(dout), 32'h2AA);

    // Divider change mid-period takes effect only after the current period
    do_reset();
    drive(1'b1, 9, 3'b001, 10'h111, '0, '0);
    @(posedge clk);
    #1;
    repeat (2) @(posedge clk);
    #1 div_i = DIV_W'(1);
    wait_upd(n);
    check("div_chg_first_period", n + 2, 10);
    wait_upd(n);
    check("div_chg_second_period", n, 2);
    wait_upd(n);
    check("div_chg_third_period", n, 2);
    check("div_chg_dout", 32'(dout), 32'h111);

    // Randomized run against the reference model
    do_reset();
    model_reset();
    drive(1'b1, 2, '0, '0, '0, '0);
    for (int c = 0; c < 2500; c++) begin
      en_i = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) div_i = DIV_W'($urandom_range(0, 4));
      req_valid_i = NREQ'($urandom);
      if ($urandom_range(0, 3) == 0) req_valid_i = '0;
      for (int r = 0; r < NREQ; r++) req_data_i[r*DW +: DW] = DW'($urandom);
      #1;
      model_cycle();
      @(posedge clk);
      #1;
      model_check_regs();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
